turtle_motion: RTL



---
 rtl/turtle_motion_if.sv | 25 ++
 rtl/turtle_motion.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/turtle_motion_if.sv
// Signal bundle between the turtle motion controller and its environment
// (playfield/collision inputs in, sprite-state and hit-logic outputs out).
interface turtle_motion_if;
  logic        frame_tick;
  logic        initial_show;
  logic        wall_left;
  logic        wall_right;
  logic        stomp;
  logic [10:0] x;
  logic        oriental;
  logic        collapsion_impulse;
  logic        press_impulse;
  logic        clk_walk_anim;
  logic        lethal;

  modport master (
    output frame_tick, initial_show, wall_left, wall_right, stomp,
    input  x, oriental, collapsion_impulse, press_impulse, clk_walk_anim, lethal
  );

  modport slave (
    input  frame_tick, initial_show, wall_left, wall_right, stomp,
    output x, oriental, collapsion_impulse, press_impulse, clk_walk_anim, lethal
  );
endinterface

// File: rtl/turtle_motion.sv
// Turtle movement/interaction controller: owns x position, walk direction and
// the IDLE/WALK/SHELL/SLIDE state, and emits toggle-style impulses for the sprite block.
module turtle_motion #(
  parameter int X_INIT     = 400,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 1247,
  parameter int WALK_DIV   = 4,
  parameter int SLIDE_STEP = 6,
  parameter int ANIM_DIV   = 8
) (
  input logic            clk,
  input logic            rstn,
  turtle_motion_if.slave bus
);

  localparam int SW = (WALK_DIV > 1) ? $clog2(WALK_DIV) : 1;
  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_SHELL, S_SLIDE} state_t;

  state_t          state_q, state_d;
  logic [10:0]     x_q, x_d;
  logic            orient_q, orient_d;
  logic            coll_q, coll_d;
  logic            press_q, press_d;
  logic            anim_q, anim_d;
  logic [SW-1:0]   step_cnt_q, step_cnt_d;
  logic [AW-1:0]   anim_cnt_q, anim_cnt_d;
  logic            blocked;
  logic [11:0]     mv;

  // Returns {flip, new_x}; 12-bit math so a left step below X_MIN is caught
  // before it wraps, and the wall check takes priority over the bound check.
  function automatic logic [11:0] move_x(input logic [10:0] x, input logic left,
                                         input logic [10:0] step, input logic wall);
    logic [11:0] xe, se, nx;
    xe = {1'b0, x};
    se = {1'b0, step};
    nx = '0;
    if (wall) begin
      move_x = {1'b1, x};
    end else if (left) begin
      nx = xe - se;
      if (xe < se + 12'(X_MIN)) move_x = {1'b1, 11'(X_MIN)};
      else                      move_x = {1'b0, nx[10:0]};
    end else begin
      nx = xe + se;
      if (nx > 12'(X_MAX)) move_x = {1'b1, 11'(X_MAX)};
      else                 move_x = {1'b0, nx[10:0]};
    end
  endfunction

  assign blocked = orient_q ? bus.wall_left : bus.wall_right;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    orient_d   = orient_q;
    coll_d     = coll_q;
    press_d    = press_q;
    anim_d     = anim_q;
    step_cnt_d = step_cnt_q;
    anim_cnt_d = anim_cnt_q;
    mv         = {1'b0, x_q};
    if (!bus.initial_show) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d    = S_WALK;
          step_cnt_d = '0;
          anim_cnt_d = '0;
        end
        S_WALK: begin
          if (bus.stomp) begin
            state_d    = S_SHELL;
            press_d    = ~press_q;
            step_cnt_d = '0;
          end else if (bus.frame_tick) begin
            if (anim_cnt_q == AW'(ANIM_DIV - 1)) begin
              anim_cnt_d = '0;
              anim_d     = ~anim_q;
            end else begin
              anim_cnt_d = anim_cnt_q + 1'b1;
            end
            if (step_cnt_q == SW'(WALK_DIV - 1)) begin
              step_cnt_d = '0;
              mv         = move_x(x_q, orient_q, 11'd1, blocked);
              x_d        = mv[10:0];
              if (mv[11]) begin
                orient_d = ~orient_q;
                coll_d   = ~coll_q;
              end
            end else begin
              step_cnt_d = step_cnt_q + 1'b1;
            end
          end
        end
        S_SHELL: begin
          if (bus.stomp) begin
            state_d = S_SLIDE;
            press_d = ~press_q;
          end
        end
        S_SLIDE: begin
          if (bus.stomp) begin
            state_d = S_SHELL;
            press_d = ~press_q;
          end else if (bus.frame_tick) begin
            mv  = move_x(x_q, orient_q, 11'(SLIDE_STEP), blocked);
            x_d = mv[10:0];
            if (mv[11]) begin
              orient_d = ~orient_q;
              coll_d   = ~coll_q;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q    <= S_IDLE;
      x_q        <= 11'(X_INIT);
      orient_q   <= 1'b1;
      coll_q     <= 1'b0;
      press_q    <= 1'b0;
      anim_q     <= 1'b0;
      step_cnt_q <= '0;
      anim_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      orient_q   <= orient_d;
      coll_q     <= coll_d;
      press_q    <= press_d;
      anim_q     <= anim_d;
      step_cnt_q <= step_cnt_d;
      anim_cnt_q <= anim_cnt_d;
    end
  end

  assign bus.x                  = x_q;
  assign bus.oriental           = orient_q;
  assign bus.collapsion_impulse = coll_q;
  assign bus.press_impulse      = press_q;
  assign bus.clk_walk_anim      = anim_q;
  assign bus.lethal             = (state_q == S_WALK) || (state_q == S_SLIDE);

endmodule
